mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the CPU instruction-fetch path and the data load/store path.
- Allows at most one outstanding transaction, with fixed memory read latency.
- Simultaneous requests are arbitrated round-robin.
- Each grant cycle issues the memory command; read data or write acknowledge returns to the owner exactly MEM_LAT cycles later.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter.
package mem_arb_pkg;

    // IDLE: nothing outstanding. WAIT: counting down to the response cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

    // Which requester owns the outstanding transaction.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Data is treated as the last winner out of reset, so fetch wins the first tie.
    localparam owner_e LAST_GRANT_RST = OWN_D;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,        // [0] = fetch, [1] = data
    input  owner_e     last_grant,
    input  logic       en,
    output logic [1:0] gnt,        // one-hot, all zero when en is low
    output owner_e     winner
);

    // Pick the winner and gate the one-hot grant with the enable.
    always_comb begin
        winner = OWN_IF;
        if (req[1] && (!req[0] || (last_grant == OWN_IF))) begin
            winner = OWN_D;
        end
        gnt = 2'b00;
        if (en && (req != 2'b00)) begin
            gnt = (winner == OWN_D) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store.
// One transaction may be outstanding; its response returns MEM_LAT cycles after
// the command. A new command may be issued in the response cycle of the previous one.
//
// Handshake: a requester raises req with address/data and holds them until it sees
// gnt in the same cycle; the command is taken in that cycle only. Exactly MEM_LAT
// cycles later rvalid pulses for one cycle (load data, or a store acknowledge with
// zero data). There is no backpressure on rvalid. busy_o mirrors the FSM state
// (1 = WAIT) for observation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_wr_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    owner_e           owner_q;
    owner_e           last_grant_q;
    logic             is_wr_q;

    logic             resp_cycle;
    logic             can_grant;
    logic             grant;
    logic [1:0]       gnt;
    owner_e           winner;

    // The response cycle doubles as a grant slot so transactions can run back to back.
    // Gating with rst keeps every output low while reset is held, even with requests up.
    assign resp_cycle = (state_q == ST_WAIT) && (cnt_q == '0);
    assign can_grant  = rst && ((state_q == ST_IDLE) || resp_cycle);
    assign grant      = |gnt;

    rr_arb2 u_rr_arb2 (
        .req        ({d_req_i, if_req_i}),
        .last_grant (last_grant_q),
        .en         (can_grant),
        .gnt        (gnt),
        .winner     (winner)
    );

    // Grant-cycle memory command and response-cycle return path.
    always_comb begin
        if_gnt_o    = gnt[0];
        d_gnt_o     = gnt[1];
        mem_en_o    = grant;
        mem_we_o    = gnt[1] & d_wr_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (grant) begin
            mem_addr_o  = (winner == OWN_D) ? d_addr_i : if_addr_i;
            mem_wdata_o = d_wdata_i;
        end
        if_rvalid_o = resp_cycle && (owner_q == OWN_IF);
        d_rvalid_o  = resp_cycle && (owner_q == OWN_D);
        if_rdata_o  = (if_rvalid_o && !is_wr_q) ? mem_rdata_i : '0;
        d_rdata_o   = (d_rvalid_o && !is_wr_q) ? mem_rdata_i : '0;
        busy_o      = (state_q == ST_WAIT);
    end

    // FSM: capture the owner on grant, count down to the response cycle, then idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_IF;
            last_grant_q <= LAST_GRANT_RST;
            is_wr_q      <= 1'b0;
        end else if (grant) begin
            state_q      <= ST_WAIT;
            cnt_q        <= CNT_LOAD;
            owner_q      <= winner;
            last_grant_q <= winner;
            is_wr_q      <= mem_we_o;
        end else if (state_q == ST_WAIT) begin
            if (cnt_q == '0) begin
                state_q <= ST_IDLE;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a main instance with MEM_LAT=2 under directed and
// random traffic, and a MEM_LAT=1 instance for continuous single-cycle grants.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (MEM_LAT=2) ----------------
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_wr, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_wr_i(d_wr), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    // ---------------- second DUT (MEM_LAT=1) ----------------
    logic          l1_if_req, l1_if_gnt, l1_if_rvalid;
    logic [AW-1:0] l1_if_addr;
    logic [DW-1:0] l1_if_rdata;
    logic          l1_d_req, l1_d_wr, l1_d_gnt, l1_d_rvalid;
    logic [AW-1:0] l1_d_addr;
    logic [DW-1:0] l1_d_wdata, l1_d_rdata;
    logic          l1_mem_en, l1_mem_we, l1_busy;
    logic [AW-1:0] l1_mem_addr;
    logic [DW-1:0] l1_mem_wdata, l1_mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .if_req_i(l1_if_req), .if_addr_i(l1_if_addr), .if_gnt_o(l1_if_gnt),
        .if_rvalid_o(l1_if_rvalid), .if_rdata_o(l1_if_rdata),
        .d_req_i(l1_d_req), .d_wr_i(l1_d_wr), .d_addr_i(l1_d_addr), .d_wdata_i(l1_d_wdata),
        .d_gnt_o(l1_d_gnt), .d_rvalid_o(l1_d_rvalid), .d_rdata_o(l1_d_rdata),
        .mem_en_o(l1_mem_en), .mem_we_o(l1_mem_we), .mem_addr_o(l1_mem_addr),
        .mem_wdata_o(l1_mem_wdata), .mem_rdata_i(l1_mem_rdata), .busy_o(l1_busy)
    );

    // ---------------- counters / compare ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {~a[15:0], a[15:0] ^ 16'h5A3C};
    endfunction

    // Memory device behind the main DUT port (environment, not the model).
    logic [DW-1:0] mem_arr  [logic [AW-1:0]];
    logic [DW-1:0] rd_sched [int];

    function automatic logic [DW-1:0] dev_read(input logic [AW-1:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
    endfunction

    always @(negedge clk) begin
        if (rst && mem_en) begin
            if (mem_we) mem_arr[mem_addr] = mem_wdata;
            else        rd_sched[cyc + LAT] = dev_read(mem_addr);
        end
    end

    always @(posedge clk) begin
        #1;
        mem_rdata = rd_sched.exists(cyc) ? rd_sched[cyc] : $urandom;
    end

    // Memory device behind the MEM_LAT=1 instance (read-only contents).
    logic [DW-1:0] l1_next;
    bit            l1_has = 1'b0;
    always @(negedge clk) begin
        l1_has  = l1_mem_en && !l1_mem_we;
        l1_next = init_word(l1_mem_addr);
    end
    always @(posedge clk) begin
        #1;
        l1_mem_rdata = l1_has ? l1_next : $urandom;
    end

    // ---------------- reference model ----------------
    // Memory as the requesters expect to see it; fetch and data use disjoint
    // address regions, so expected data does not depend on grant order.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Scoreboard: expected response data and the cycle it must appear in.
    logic [DW-1:0] if_exp_q[$];
    logic [DW-1:0] d_exp_q[$];
    int            if_cyc_q[$];
    int            d_cyc_q[$];

    // Arbitration model: the port is free from last grant + LAT on; ties go to
    // whoever did not win last (1 = data).
    bit mon_on       = 1'b0;
    bit last_winner  = 1'b1;
    int last_gnt_cyc = -1000;

    task automatic reset_model();
        last_winner  = 1'b1;
        last_gnt_cyc = -1000;
        if_exp_q.delete();
        d_exp_q.delete();
        if_cyc_q.delete();
        d_cyc_q.delete();
        rd_sched.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst && mon_on) begin
            bit exp_grant, exp_d, exp_busy, exp_ifv, exp_dv;
            exp_busy  = (cyc > last_gnt_cyc) && (cyc <= last_gnt_cyc + LAT);
            exp_grant = (cyc >= last_gnt_cyc + LAT) && (if_req || d_req);
            exp_d     = d_req && (!if_req || (last_winner == 1'b0));

            check("busy", 64'(busy), 64'(exp_busy));
            check("gnt_any", 64'(if_gnt | d_gnt), 64'(exp_grant));
            check("gnt_both", 64'(if_gnt & d_gnt), 64'd0);
            if (exp_grant) begin
                check("gnt_d", 64'(d_gnt), 64'(exp_d));
                check("mem_en", 64'(mem_en), 64'd1);
                check("mem_addr", 64'(mem_addr), 64'(exp_d ? d_addr : if_addr));
                check("mem_we", 64'(mem_we), 64'(exp_d & d_wr));
                check("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
                last_winner  = exp_d;
                last_gnt_cyc = cyc;
            end else begin
                check("mem_idle_ctl", {62'd0, mem_en, mem_we}, 64'd0);
                check("mem_idle_bus", {mem_addr, mem_wdata}, 64'd0);
            end

            exp_ifv = (if_cyc_q.size() != 0) && (if_cyc_q[0] == cyc);
            check("if_rvalid", 64'(if_rvalid), 64'(exp_ifv));
            if (exp_ifv) begin
                check("if_rdata", 64'(if_rdata), 64'(if_exp_q.pop_front()));
                void'(if_cyc_q.pop_front());
            end else begin
                check("if_rdata_idle", 64'(if_rdata), 64'd0);
            end

            exp_dv = (d_cyc_q.size() != 0) && (d_cyc_q[0] == cyc);
            check("d_rvalid", 64'(d_rvalid), 64'(exp_dv));
            if (exp_dv) begin
                check("d_rdata", 64'(d_rdata), 64'(d_exp_q.pop_front()));
                void'(d_cyc_q.pop_front());
            end else begin
                check("d_rdata_idle", 64'(d_rdata), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end one time unit after a rising edge.
    task automatic if_txn(input logic [AW-1:0] a, input bit may_abandon,
                          output bit granted, output int gcyc);
        int limit;
        granted = 1'b0;
        gcyc    = -1;
        limit   = may_abandon ? 1 : 40;
        if_req  = 1'b1;
        if_addr = a;
        for (int w = 0; w < limit && !granted; w++) begin
            @(negedge clk);
            if (if_gnt === 1'b1) begin
                granted = 1'b1;
                gcyc    = cyc;
                if_exp_q.push_back(ref_read(a));
                if_cyc_q.push_back(cyc + LAT);
            end
            @(posedge clk); #1;
        end
        if_req  = 1'b0;
        if_addr = $urandom;
        if (!granted && !may_abandon) check("if_gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic d_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input bit may_abandon, output bit granted, output int gcyc);
        int limit;
        granted = 1'b0;
        gcyc    = -1;
        limit   = may_abandon ? 1 : 40;
        d_req   = 1'b1;
        d_wr    = wr;
        d_addr  = a;
        d_wdata = wd;
        for (int w = 0; w < limit && !granted; w++) begin
            @(negedge clk);
            if (d_gnt === 1'b1) begin
                granted = 1'b1;
                gcyc    = cyc;
                if (wr) begin
                    ref_mem[a] = wd;
                    d_exp_q.push_back('0);
                end else begin
                    d_exp_q.push_back(ref_read(a));
                end
                d_cyc_q.push_back(cyc + LAT);
            end
            @(posedge clk); #1;
        end
        d_req   = 1'b0;
        d_wr    = 1'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
        if (!granted && !may_abandon) check("d_gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic if_drv(input int n, input int max_gap, input int abandon_pct);
        bit g;
        int gc, gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, max_gap);
            repeat (gap) begin @(posedge clk); #1; end
            if_txn(32'h1000 + 4 * $urandom_range(0, 255),
                   $urandom_range(0, 99) < abandon_pct, g, gc);
        end
    endtask

    task automatic d_drv(input int n, input int max_gap, input int abandon_pct);
        bit g;
        int gc, gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, max_gap);
            repeat (gap) begin @(posedge clk); #1; end
            d_txn(1'($urandom_range(0, 1)), 32'h2000 + 4 * $urandom_range(0, 15), $urandom,
                  $urandom_range(0, 99) < abandon_pct, g, gc);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((if_exp_q.size() + d_exp_q.size() != 0) && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain", 64'(if_exp_q.size() + d_exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {57'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}, 64'd0);
        check({tag, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
        check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        rst    = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        reset_model();
        mon_on = 1'b1;
    endtask

    task automatic lat1_test();
        for (int k = 0; k < 10; k++) begin
            l1_if_req  = 1'b1;
            l1_if_addr = 32'h3000 + 4 * k;
            @(negedge clk);
            check("l1_gnt", 64'(l1_if_gnt), 64'd1);
            check("l1_rvalid", 64'(l1_if_rvalid), 64'(k > 0));
            check("l1_rdata", 64'(l1_if_rdata),
                  (k > 0) ? 64'(init_word(32'h3000 + 4 * (k - 1))) : 64'd0);
            @(posedge clk); #1;
        end
        l1_if_req = 1'b0;
        @(negedge clk);
        check("l1_last_rvalid", 64'(l1_if_rvalid), 64'd1);
        check("l1_last_rdata", 64'(l1_if_rdata), 64'(init_word(32'h3000 + 4 * 9)));
        check("l1_last_gnt", 64'(l1_if_gnt), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_idle_busy", 64'(l1_busy), 64'd0);
        check("l1_idle_rvalid", 64'(l1_if_rvalid), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    bit g1, g2;
    int c1, c2;

    initial begin
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0;
        l1_if_req = 1'b0; l1_if_addr = '0;
        l1_d_req = 1'b0; l1_d_wr = 1'b0; l1_d_addr = '0; l1_d_wdata = '0;
        l1_mem_rdata = '0;

        // Single fetch with a known instruction word.
        do_reset();
        repeat (2) begin @(posedge clk); #1; end
        mem_arr[32'h10] = 32'h00A00093;
        ref_mem[32'h10] = 32'h00A00093;
        if_txn(32'h10, 1'b0, g1, c1);
        drain();

        // Simultaneous fetch and load right after reset: fetch first, load back to back.
        do_reset();
        fork
            if_txn(32'h1004, 1'b0, g1, c1);
            d_txn(1'b0, 32'h40, 32'h0, 1'b0, g2, c2);
        join
        check("t2_if_first", 64'(g1 && g2 && (c1 < c2)), 64'd1);
        check("t2_b2b", 64'(c2 - c1), 64'(LAT));
        drain();

        // Both requesters held continuously: alternating grants with no gaps.
        fork
            if_drv(8, 0, 0);
            d_drv(8, 0, 0);
        join
        drain();

        // Store then load back the same word.
        d_txn(1'b1, 32'h44, 32'hDEADBEEF, 1'b0, g1, c1);
        drain();
        d_txn(1'b0, 32'h44, 32'h0, 1'b0, g1, c1);
        drain();

        // Random mixed traffic with gaps and abandoned requests.
        fork
            if_drv(40, 3, 20);
            d_drv(40, 3, 20);
        join
        drain();

        // Reset in the cycle after a load grant: outputs clear and the load is dropped.
        d_txn(1'b0, 32'h2008, 32'h0, 1'b0, g1, c1);
        check("t5_granted", 64'(g1), 64'd1);
        mon_on = 1'b0;
        rst    = 1'b0;
        if_req = 1'b1;
        d_req  = 1'b1;
        #1;
        check_all_zero("t5_rst");
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        rst    = 1'b1;
        mon_on = 1'b1;
        repeat (6) begin @(posedge clk); #1; end

        // MEM_LAT=1 instance with a continuous fetch stream.
        lat1_test();

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
